// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the fetch redirect unit and its fetch buffer.
//   fetch_state_e : request sequencer states (IDLE / WAIT / DISCARD)
//   PC_STEP       : byte increment between sequential fetches
//   FETCH_BUF_DEPTH: number of fetch buffer entries (fixed)
//   fetch_entry_t : buffered instruction word plus its fetch PC
//   sat_add16     : 16-bit saturating accumulate helper for event counters
// ---------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

    localparam int unsigned PC_STEP         = 32'd4;
    localparam int unsigned FETCH_BUF_DEPTH = 32'd2;

    // pc is carried at full 32-bit width; users keep only their PC_W low bits
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [15:0] sat_add16(input logic [15:0] acc, input logic [2:0] inc);
        logic [16:0] sum;
        sum = {1'b0, acc} + {14'd0, inc};
        if (sum[16]) begin
            return 16'hFFFF;
        end else begin
            return sum[15:0];
        end
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// ---------------------------------------------------------------------------
// fetch_buffer
// Two-entry FIFO holding fetched instructions until IF/ID consumes them.
// Clear dominates push and pop.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   push          : write push_entry at the tail (ignored when full and not popping)
//   pop           : remove the head (ignored when empty)
//   clear         : drop all entries at this edge
//   push_entry    : entry to write
//   count         : current occupancy (0..2)
//   head          : oldest entry (meaningful when count != 0)
// ---------------------------------------------------------------------------
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  fetch_entry_t push_entry,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t entries_r [FETCH_BUF_DEPTH];
    logic         wr_ptr_r;
    logic         rd_ptr_r;
    logic [1:0]   count_r;
    logic         do_pop_s;
    logic         do_push_s;

    assign do_pop_s  = pop && (count_r != 2'd0);
    assign do_push_s = push && ((count_r != 2'd2) || do_pop_s);

    // Entry storage: written at the tail on an accepted push.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            entries_r[0] <= 64'd0;
            entries_r[1] <= 64'd0;
        end else if (do_push_s && !clear) begin
            entries_r[wr_ptr_r] <= push_entry;
        end else begin
            entries_r[wr_ptr_r] <= entries_r[wr_ptr_r];
        end
    end

    // Pointers and occupancy; clear wins over everything else.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else if (clear) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            wr_ptr_r <= do_push_s ? ~wr_ptr_r : wr_ptr_r;
            rd_ptr_r <= do_pop_s  ? ~rd_ptr_r : rd_ptr_r;
            count_r  <= count_r + {1'b0, do_push_s} - {1'b0, do_pop_s};
        end
    end

    assign count = count_r;
    assign head  = entries_r[rd_ptr_r];

endmodule

// File: rtl/fetch_redirect_unit.sv
// ---------------------------------------------------------------------------
// fetch_redirect_unit
// Fetch-stage PC sequencer. Owns the fetch PC, runs a req/ack handshake to
// instruction memory, buffers returned words for IF/ID, squashes wrong-path
// fetches on a branch-unit redirect and raises the pipeline flushes.
//
// Optional build macro FETCH_REDIRECT_STATS_EN adds saturating counters
// RedirectCnt (cycles with PcSel) and SquashCnt (dropped acks plus buffer
// entries cleared by a redirect).
//
// Ports:
//   clk, reset_n       : clock, asynchronous active-low reset
//   Stall              : 1 = IF/ID does not consume this cycle
//   PcSel, BrPC        : redirect request and target (word aligned internally)
//   IMemReq, IMemAddr  : fetch request, held until IMemAck
//   IMemAck, IMemRdata : request accepted with data this cycle
//   InstValid, Inst, InstPC : fetch buffer head
//   FlushIFID, FlushIDEX    : pipeline squash, equal to PcSel
//   RedirectCnt, SquashCnt  : statistics (FETCH_REDIRECT_STATS_EN only)
// ---------------------------------------------------------------------------
module fetch_redirect_unit
    import fetch_pkg::*;
#(
    parameter int PC_W = 9
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            Stall,
    input  logic            PcSel,
    input  logic [31:0]     BrPC,
    output logic            IMemReq,
    output logic [PC_W-1:0] IMemAddr,
    input  logic            IMemAck,
    input  logic [31:0]     IMemRdata,
    output logic            InstValid,
    output logic [31:0]     Inst,
    output logic [PC_W-1:0] InstPC,
    output logic            FlushIFID,
    output logic            FlushIDEX
`ifdef FETCH_REDIRECT_STATS_EN
    ,
    output logic [15:0]     RedirectCnt,
    output logic [15:0]     SquashCnt
`endif
);

    localparam logic [1:0]      BUF_DEPTH = 2'(FETCH_BUF_DEPTH);
    localparam logic [PC_W-1:0] PC_INC    = PC_W'(PC_STEP);

    fetch_state_e    state_r;
    fetch_state_e    state_nxt_s;
    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] discard_addr_r;
    logic [PC_W-1:0] target_s;
    logic [1:0]      buf_count_s;
    logic [1:0]      occ_after_pop_s;
    logic [1:0]      occ_after_ack_s;
    fetch_entry_t    buf_head_s;
    fetch_entry_t    push_entry_s;
    logic            inst_valid_s;
    logic            pop_s;
    logic            ack_take_s;
    logic            push_s;
    logic            drop_s;
    logic            unused_s;

    assign target_s        = {BrPC[PC_W-1:2], 2'b00};
    assign inst_valid_s    = (buf_count_s != 2'd0);
    assign pop_s           = inst_valid_s && !Stall;
    // A request is only launched when a slot is certain to be free at ack time:
    // nothing else can push while that request is outstanding.
    assign occ_after_pop_s = buf_count_s - {1'b0, pop_s};
    assign ack_take_s      = IMemReq && IMemAck;
    assign push_s          = ack_take_s && !PcSel && (state_r != DISCARD);
    assign drop_s          = ack_take_s && (PcSel || (state_r == DISCARD));
    assign occ_after_ack_s = occ_after_pop_s + {1'b0, push_s};
    // In IDLE/WAIT the outstanding address is always pc_r.
    assign push_entry_s    = '{inst: IMemRdata, pc: 32'(pc_r)};

`ifdef FETCH_REDIRECT_STATS_EN
    assign unused_s = ^{BrPC[31:PC_W], BrPC[1:0], buf_head_s.pc[31:PC_W]};
`else
    assign unused_s = ^{BrPC[31:PC_W], BrPC[1:0], buf_head_s.pc[31:PC_W], drop_s};
`endif

    fetch_buffer u_fetch_buffer (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push_s),
        .pop        (pop_s),
        .clear      (PcSel),
        .push_entry (push_entry_s),
        .count      (buf_count_s),
        .head       (buf_head_s)
    );

    // Sequencer state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Sequencer next-state logic; a redirect with a same-cycle ack lands in IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (PcSel) begin
                    state_nxt_s = IDLE;
                end else if (IMemReq && !IMemAck) begin
                    state_nxt_s = WAIT;
                end else if (ack_take_s && (occ_after_ack_s < BUF_DEPTH)) begin
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (ack_take_s) begin
                    if (PcSel) begin
                        state_nxt_s = IDLE;
                    end else if (occ_after_ack_s < BUF_DEPTH) begin
                        state_nxt_s = WAIT;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else if (PcSel) begin
                    state_nxt_s = DISCARD;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            DISCARD: begin
                if (ack_take_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DISCARD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Sequencer outputs; IDLE issues combinationally so a redirect or a
    // discarded ack is followed by the new request on the very next cycle.
    always_comb begin
        IMemReq   = 1'b0;
        IMemAddr  = pc_r;
        case (state_r)
            IDLE: begin
                IMemReq  = reset_n && !PcSel && (occ_after_pop_s < BUF_DEPTH);
                IMemAddr = pc_r;
            end
            WAIT: begin
                IMemReq  = reset_n;
                IMemAddr = pc_r;
            end
            DISCARD: begin
                IMemReq  = reset_n;
                IMemAddr = discard_addr_r;
            end
            default: begin
                IMemReq  = 1'b0;
                IMemAddr = pc_r;
            end
        endcase
        InstValid = inst_valid_s;
        Inst      = inst_valid_s ? buf_head_s.inst : 32'd0;
        InstPC    = inst_valid_s ? buf_head_s.pc[PC_W-1:0] : {PC_W{1'b0}};
        FlushIFID = PcSel;
        FlushIDEX = PcSel;
    end

    // Fetch PC: redirect beats sequential advance; wraps naturally at 2^PC_W.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_r <= {PC_W{1'b0}};
        end else if (PcSel) begin
            pc_r <= target_s;
        end else if (push_s) begin
            pc_r <= pc_r + PC_INC;
        end else begin
            pc_r <= pc_r;
        end
    end

    // Address of the abandoned request, held stable while it drains in DISCARD.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            discard_addr_r <= {PC_W{1'b0}};
        end else if ((state_r == WAIT) && (state_nxt_s == DISCARD)) begin
            discard_addr_r <= pc_r;
        end else begin
            discard_addr_r <= discard_addr_r;
        end
    end

`ifdef FETCH_REDIRECT_STATS_EN
    logic [2:0] squash_inc_s;

    assign squash_inc_s = {2'b00, drop_s} + (PcSel ? {1'b0, buf_count_s} : 3'd0);

    // Saturating redirect / squash event counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            RedirectCnt <= 16'd0;
            SquashCnt   <= 16'd0;
        end else begin
            RedirectCnt <= sat_add16(RedirectCnt, {2'b00, PcSel});
            SquashCnt   <= sat_add16(SquashCnt, squash_inc_s);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_redirect_unit
// Table-driven bench for fetch_redirect_unit with a behavioural instruction
// memory (configurable ack latency) and an expected-instruction scoreboard.
// ---------------------------------------------------------------------------
module tb_fetch_redirect_unit;

    logic        clk;
    logic        reset_n;
    logic        Stall;
    logic        PcSel;
    logic [31:0] BrPC;
    logic        IMemReq;
    logic [8:0]  IMemAddr;
    logic        IMemAck;
    logic [31:0] IMemRdata;
    logic        InstValid;
    logic [31:0] Inst;
    logic [8:0]  InstPC;
    logic        FlushIFID;
    logic        FlushIDEX;
`ifdef FETCH_REDIRECT_STATS_EN
    logic [15:0] RedirectCnt;
    logic [15:0] SquashCnt;
`endif

    fetch_redirect_unit #(.PC_W(9)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .Stall     (Stall),
        .PcSel     (PcSel),
        .BrPC      (BrPC),
        .IMemReq   (IMemReq),
        .IMemAddr  (IMemAddr),
        .IMemAck   (IMemAck),
        .IMemRdata (IMemRdata),
        .InstValid (InstValid),
        .Inst      (Inst),
        .InstPC    (InstPC),
        .FlushIFID (FlushIFID),
        .FlushIDEX (FlushIDEX)
`ifdef FETCH_REDIRECT_STATS_EN
        ,
        .RedirectCnt (RedirectCnt),
        .SquashCnt   (SquashCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [8:0]  pc;
    } exp_t;

    typedef struct {
        logic        first;
        int          lat;
        logic        st;
        logic        ps;
        logic [31:0] br;
        logic        ereq;
        logic [8:0]  eaddr;
    } vec_t;

    exp_t sb[$];
    vec_t vt[$];

    int   nchk;
    int   nfail;
    int   lat;
    int   wait_cnt;
    logic pend;
    logic [8:0] pend_addr;
    logic disc;

    function automatic logic [31:0] mk(input logic [8:0] a);
        return {16'hC0DE, 7'd0, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic addv(input logic first, input int l, input logic st, input logic ps,
                        input logic [31:0] br, input logic ereq, input logic [8:0] eaddr);
        vec_t v;
        v.first = first; v.lat = l; v.st = st; v.ps = ps; v.br = br;
        v.ereq = ereq; v.eaddr = eaddr;
        vt.push_back(v);
    endtask

    task automatic clear_model();
        sb.delete();
        disc     = 1'b0;
        pend     = 1'b0;
        wait_cnt = 0;
    endtask

    // Enters and leaves at posedge+1; reset released on exit.
    task automatic do_reset();
        reset_n = 1'b0; Stall = 1'b0; PcSel = 1'b0; BrPC = 32'd0;
        IMemAck = 1'b0; IMemRdata = 32'd0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(IMemReq), 32'd0);
        chk("rst_addr", 32'(IMemAddr), 32'd0);
        chk("rst_valid", 32'(InstValid), 32'd0);
        chk("rst_inst", Inst, 32'd0);
        chk("rst_instpc", 32'(InstPC), 32'd0);
        chk("rst_flush", 32'({FlushIFID, FlushIDEX}), 32'd0);
`ifdef FETCH_REDIRECT_STATS_EN
        chk("rst_redirect_cnt", 32'(RedirectCnt), 32'd0);
        chk("rst_squash_cnt", 32'(SquashCnt), 32'd0);
`endif
        clear_model();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // One clock cycle: drive inputs, model memory, check outputs, update scoreboard.
    task automatic step(input logic st, input logic ps, input logic [31:0] br,
                        output logic req_o, output logic [8:0] addr_o);
        logic ack_v;
        exp_t e;
        Stall = st; PcSel = ps; BrPC = br; IMemAck = 1'b0; IMemRdata = 32'd0;
        #1;
        ack_v = IMemReq && (wait_cnt == lat);
        if (IMemReq && pend) chk("addr_stable", 32'(IMemAddr), 32'(pend_addr));
        IMemAck   = ack_v;
        IMemRdata = ack_v ? mk(IMemAddr) : 32'd0;
        #1;
        req_o  = IMemReq;
        addr_o = IMemAddr;
        @(negedge clk);
        chk("flush_ifid", 32'(FlushIFID), 32'(ps));
        chk("flush_idex", 32'(FlushIDEX), 32'(ps));
        chk("inst_valid", 32'(InstValid), 32'(sb.size() != 0));
        if (InstValid && (sb.size() != 0)) begin
            chk("inst", Inst, sb[0].inst);
            chk("inst_pc", 32'(InstPC), 32'(sb[0].pc));
        end
        if (ps) begin
            sb.delete();
        end else begin
            if ((sb.size() != 0) && !st) void'(sb.pop_front());
            if (ack_v && !disc) begin
                e.inst = mk(addr_o);
                e.pc   = addr_o;
                sb.push_back(e);
            end
        end
        if (ack_v) disc = 1'b0;
        else if (req_o && ps) disc = 1'b1;
        pend      = req_o && !ack_v;
        pend_addr = addr_o;
        wait_cnt  = pend ? wait_cnt + 1 : 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic       r;
        logic [8:0] a;
        nchk = 0; nfail = 0; lat = 0;
        reset_n = 1'b0; Stall = 1'b0; PcSel = 1'b0; BrPC = 32'd0;
        IMemAck = 1'b0; IMemRdata = 32'd0;
        clear_model();

        // Zero-wait sequential fetch
        addv(1, 0, 0, 0, 32'd0,   1, 9'h000);
        addv(0, 0, 0, 0, 32'd0,   1, 9'h004);
        addv(0, 0, 0, 0, 32'd0,   1, 9'h008);
        addv(0, 0, 0, 0, 32'd0,   1, 9'h00C);
        // Redirect while waiting on a slow ack
        addv(1, 3, 0, 0, 32'd0,   1, 9'h000);
        addv(0, 3, 0, 1, 32'h40,  1, 9'h000);
        addv(0, 3, 0, 0, 32'd0,   1, 9'h000);
        addv(0, 3, 0, 0, 32'd0,   1, 9'h000);
        addv(0, 3, 0, 0, 32'd0,   1, 9'h040);
        // Stall fills the buffer, release drains it
        addv(1, 0, 1, 0, 32'd0,   1, 9'h000);
        addv(0, 0, 1, 0, 32'd0,   1, 9'h004);
        addv(0, 0, 1, 0, 32'd0,   0, 9'h008);
        addv(0, 0, 1, 0, 32'd0,   0, 9'h008);
        addv(0, 0, 0, 0, 32'd0,   1, 9'h008);
        addv(0, 0, 0, 0, 32'd0,   1, 9'h00C);
        // PC wrap at 2^9
        addv(1, 0, 0, 1, 32'h1F8, 0, 9'h000);
        addv(0, 0, 0, 0, 32'd0,   1, 9'h1F8);
        addv(0, 0, 0, 0, 32'd0,   1, 9'h1FC);
        addv(0, 0, 0, 0, 32'd0,   1, 9'h000);
        // Redirect with same-cycle ack, unaligned target
        addv(1, 0, 0, 0, 32'd0,   1, 9'h000);
        addv(0, 0, 0, 1, 32'h23,  1, 9'h004);
        addv(0, 0, 0, 0, 32'd0,   1, 9'h020);
        addv(0, 0, 0, 0, 32'd0,   1, 9'h024);
        // Second redirect while discarding
        addv(1, 3, 0, 0, 32'd0,   1, 9'h000);
        addv(0, 3, 0, 1, 32'h40,  1, 9'h000);
        addv(0, 3, 0, 1, 32'h80,  1, 9'h000);
        addv(0, 3, 0, 0, 32'd0,   1, 9'h000);
        addv(0, 3, 0, 0, 32'd0,   1, 9'h080);

        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].first) do_reset();
            lat = vt[i].lat;
            step(vt[i].st, vt[i].ps, vt[i].br, r, a);
            chk($sformatf("req[%0d]", i), 32'(r), 32'(vt[i].ereq));
            if (vt[i].ereq) chk($sformatf("addr[%0d]", i), 32'(a), 32'(vt[i].eaddr));
        end

`ifdef FETCH_REDIRECT_STATS_EN
        chk("redirect_cnt", 32'(RedirectCnt), 32'd2);
        chk("squash_cnt", 32'(SquashCnt), 32'd1);
`endif

        // Asynchronous reset in the middle of an outstanding request
        do_reset();
        lat = 3;
        step(1'b0, 1'b0, 32'd0, r, a);
        chk("mid_req0", 32'(r), 32'd1);
        step(1'b0, 1'b0, 32'd0, r, a);
        chk("mid_req1", 32'(r), 32'd1);
        reset_n = 1'b0;
        IMemAck = 1'b1;
        IMemRdata = 32'hDEAD_BEEF;
        #1;
        chk("async_req", 32'(IMemReq), 32'd0);
        chk("async_addr", 32'(IMemAddr), 32'd0);
        chk("async_valid", 32'(InstValid), 32'd0);
        chk("async_inst", Inst, 32'd0);
        chk("async_instpc", 32'(InstPC), 32'd0);
`ifdef FETCH_REDIRECT_STATS_EN
        chk("async_redirect_cnt", 32'(RedirectCnt), 32'd0);
        chk("async_squash_cnt", 32'(SquashCnt), 32'd0);
`endif
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        IMemAck = 1'b0;
        IMemRdata = 32'd0;
        clear_model();
        lat = 0;
        step(1'b0, 1'b0, 32'd0, r, a);
        chk("refetch_req0", 32'(r), 32'd1);
        chk("refetch_addr0", 32'(a), 32'd0);
        step(1'b0, 1'b0, 32'd0, r, a);
        chk("refetch_req1", 32'(r), 32'd1);
        chk("refetch_addr1", 32'(a), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/fetch_redirect_unit.md
# fetch_redirect_unit

Fetch-stage PC sequencer. It is the consumer of the branch unit's redirect outputs (`PcSel`, `BrPC`). It owns the architectural fetch PC and drives a req/ack handshake to instruction memory. It buffers returned instructions for the IF/ID register, squashes wrong-path fetches when a taken branch or jump resolves in EX, and raises pipeline flushes.

## Interface
Parameters:
- `PC_W`, default 9: fetch PC / instruction memory byte-address width.
- `BUF_DEPTH`, fixed 2: fetch buffer entries; not user-changeable.

Ports:
- `clk`  in  1: single clock, all state on rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `Stall`  in  1: hazard unit; 1 = IF/ID does not consume this cycle.
- `PcSel`  in  1: branch unit; 1 = redirect taken this cycle.
- `BrPC`  in  32: redirect target; only `[PC_W-1:0]` used, bits `[1:0]` forced to 0.
- `IMemReq`  out  1: fetch request; held until `IMemAck`.
- `IMemAddr`  out  PC_W: request address; stable while `IMemReq`=1 and no ack.
- `IMemAck`  in  1: request accepted and `IMemRdata` valid this cycle; may be the same cycle as `IMemReq`.
- `IMemRdata`  in  32: instruction word.
- `InstValid`  out  1: buffer head valid.
- `Inst`  out  32: buffer head instruction.
- `InstPC`  out  PC_W: buffer head PC.
- `FlushIFID`  out  1: squash IF/ID.
- `FlushIDEX`  out  1: squash ID/EX.

## Operation
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: request outstanding, response wanted.
  - DISCARD: request outstanding, response to be dropped.
- IDLE→WAIT when the buffer occupancy after this cycle's pop is less than `BUF_DEPTH` and `PcSel`=0. `IMemReq`=1, `IMemAddr`=PC.
- WAIT, ack: push `{IMemRdata, IMemAddr}` and set PC = PC+4 (mod 2^PC_W, wrap 2^PC_W−4 → 0).
  - Stay in WAIT, issuing the next address the following cycle, if space allows.
  - Otherwise go to IDLE.
- WAIT, `PcSel`=1, no ack: go to DISCARD. `IMemReq` stays high with the old address until ack.
- DISCARD, ack: response dropped, go to IDLE. The new request goes out the next cycle.
- Redirect, any state:
  - PC ← target.
  - Buffer cleared at the edge.
  - An ack in the same cycle as `PcSel` is dropped, and the state goes to IDLE rather than DISCARD.
  - A second redirect while in DISCARD updates the target only.
- Pop: buffer head is removed at the edge when `InstValid`=1 and `Stall`=0.
- Priority: redirect > ack push > pop. Simultaneous push and pop keeps occupancy constant.
- Flushes: `FlushIFID` = `FlushIDEX` = `PcSel`, combinational, in the same cycle as the redirect.

## Timing
- Reset values:
  - PC=0, state IDLE, buffer empty.
  - `IMemReq`=0, `IMemAddr`=0, `InstValid`=0, `Inst`=0, `InstPC`=0.
  - Flushes follow `PcSel`.
- First `IMemReq` in the first cycle after `reset_n` deasserts.
- With zero-wait memory, sustained throughput is 1 instruction per cycle. Fetch-to-`InstValid` latency is 1 cycle after ack.
- Redirect to first target request: 1 cycle (IDLE or ack-same-cycle), or ack+1 from DISCARD.
- Buffer full with `Stall`=1: `IMemReq` stays 0. A request is never issued unless a free slot is guaranteed.
- `reset_n` asserted mid-WAIT/DISCARD: immediate return to reset values. The pending memory response is the memory's problem; the unit ignores acks while in reset.

## Configuration
- `FETCH_REDIRECT_STATS_EN` defined: adds outputs `RedirectCnt[15:0]` and `SquashCnt[15:0]`.
  - Both are saturating counters, reset to 0.
  - `RedirectCnt` counts cycles with `PcSel`=1.
  - `SquashCnt` counts dropped acks plus buffer entries cleared by redirect.
- Undefined: ports and counters are absent, and behaviour is otherwise identical.

## Structure
- `fetch_pkg` holds:
  - `fetch_state_e` enum (IDLE, WAIT, DISCARD).
  - `PC_STEP` = 4.
  - `FETCH_BUF_DEPTH` = 2.
  - `fetch_entry_t` struct {inst[31:0], pc}.
- Sub-module `fetch_buffer`: 2-entry FIFO with push, pop, clear, count, head. Clear dominates push.

## Test plan
- Reset, `IMemAck` tied to `IMemReq`, `Stall`=0 → addresses 0,4,8,12 on consecutive cycles; `InstValid` from cycle 2 with matching `InstPC`.
- Ack latency 3, `PcSel`=1 with `BrPC`=0x40 in cycle 1 of the wait → `FlushIFID`/`FlushIDEX`=1 that cycle; the ack is dropped (no `InstValid`); the next request has `IMemAddr`=0x40.
- `Stall`=1 held, zero-wait memory → exactly 2 entries buffered, `IMemReq`=0 afterwards; releasing `Stall` pops 0 then 4, and fetching resumes at 8.
- `PC_W`=9, `BrPC`=0x1F8 → fetches 0x1F8, 0x1FC, 0x000.
- `PcSel`=1 with `BrPC`=0x23 in the same cycle as `IMemAck` → response dropped, next `IMemAddr`=0x20, no DISCARD entry.
- `reset_n` pulsed low during WAIT → all outputs 0 asynchronously; refetch from 0 after release; with `FETCH_REDIRECT_STATS_EN`, counters read 0.
